timebase_scheduler: RTL and testbench
=====================================

Name: timebase_scheduler

Overview:
Programmable clock-enable scheduler. It divides the 50 MHz system clock into NUM_CH independent single-cycle tick strobes, one per consumer: ADC sampling, PWM, line-sensor polling. It replaces per-consumer divided clocks with enables on the single clk_50MHz domain. A one-deep config handshake lets the top-level FSM retune each channel's divisor at run time without glitching.

Parameters:
NUM_CH, 3, number of tick channels (1..4)
DIV_W, 16, divisor width in bits
DEF_DIV, 50, reset divisor for every channel (50 gives a 1 MHz tick)

Ports:
clk_50MHz  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high reset
cfg_valid  input  1  config request
cfg_ready  output  1  scheduler can accept a config request
cfg_ch  input  2  target channel index
cfg_div  input  DIV_W  new divisor (period in clk_50MHz cycles)
ch_en  input  NUM_CH  per-channel run enable
sync  input  1  phase-align pulse for all enabled channels
tick  output  NUM_CH  one-cycle enable strobe per channel, registered
cfg_err  output  1  sticky error flag for a bad channel index
pending  output  NUM_CH  a shadow divisor is waiting to be applied

Behaviour:
- Clocking and reset
  - Single clock clk_50MHz; reset is synchronous and active-high.
  - Reset values: tick=0, pending=0, cfg_err=0, cfg_ready=1.
  - Reset values, internal: all counters 0, all active divisors DEF_DIV, all channels IDLE.
  - Reset asserted mid-period aborts the period immediately; no tick is emitted on the reset cycle.
- Per-channel FSM
  - States: IDLE, RUN, RUN_PEND.
  - IDLE -> RUN when ch_en[i]=1 is sampled; the counter starts at 0.
  - RUN -> RUN_PEND on config accepted for channel i.
  - RUN_PEND -> RUN at terminal count, when the shadow divisor is copied into the active divisor.
  - Any state -> IDLE when ch_en[i]=0. Counter clears to 0 and tick[i]=0 on the next cycle.
  - A pending shadow value is applied immediately on entry to IDLE.
- Counting
  - Counter runs 0..div-1 and wraps to 0.
  - tick[i] is high for exactly one cycle per period.
  - First tick occurs exactly div cycles after the edge that samples ch_en[i] high; the period is div cycles thereafter.
  - Counter width is DIV_W; compare against div-1 with no overflow; max div is 2^DIV_W-1.
- Config handshake
  - A transfer occurs on a cycle with cfg_valid=1 and cfg_ready=1.
  - cfg_ready=0 while any channel is in RUN_PEND (one shadow register shared across channels).
  - cfg_valid may stay high while waiting; cfg_ch and cfg_div must stay stable until accepted.
  - Config to an IDLE channel is applied on the acceptance edge; no pending state is entered.
- Divisor clamp
  - cfg_div < 2 is clamped to 2, the minimum period.
  - There is no error for a clamped divisor.
- Bad channel index
  - cfg_ch >= NUM_CH: the transfer is accepted and discarded, and cfg_err is set.
  - cfg_err clears only on reset.
- Simultaneous events
  - Terminal count and config acceptance in the same cycle: the tick fires with the old divisor. The new divisor is pending and applies at the next terminal count.
  - sync=1 clears the counters of all RUN and RUN_PEND channels to 0. No tick is emitted in that cycle, even at terminal count.
  - A pending value stays pending through sync.
  - sync has no effect on IDLE channels.
  - ch_en falling and a config for that channel in the same cycle: the config is applied as for IDLE; the channel ends IDLE with the new divisor.

Decomposition:
- Package timebase_pkg holds:
  - the DIV_W and NUM_CH defaults;
  - constant MIN_DIV=2;
  - the channel state enum (IDLE, RUN, RUN_PEND);
  - a clamp function for cfg_div.
- Sub-module tick_channel holds one counter, the active divisor, and the FSM, and is instantiated NUM_CH times.
- The top-level block owns the shared shadow register, cfg_ready/cfg_err logic and channel decode.

Test Plan:
- Reset, ch_en=3'b001, DEF_DIV=50 -> tick[0] first high 50 cycles after enable, period 50 (1 MHz); tick[2:1] stay 0.
- Channel 0 running at 50; accept cfg_div=100 at count 20 -> one more period of 50, then period 100; pending[0]=1 until the switch, and cfg_ready=0 throughout.
- Channel 0 running; config with cfg_div=0, then later cfg_div=1 -> effective period 2 each time (tick every other cycle); cfg_err stays 0.
- Config with cfg_ch=3 while NUM_CH=3 -> accepted in 1 cycle, cfg_err=1 and held; no channel's divisor changes.
- Channels 0 and 1 at divisors 50 and 75 with offset phases; pulse sync -> both counters restart, and ticks coincide 150 cycles after sync.
- Channel 1 in RUN_PEND; deassert ch_en[1] -> tick[1]=0 next cycle, pending[1]=0, cfg_ready=1; re-enable -> first tick after the new divisor. Assert reset mid-period -> all outputs at reset values on the following cycle.

Source files
------------

// File: rtl/timebase_pkg.sv
// Shared constants, channel state encoding and divisor clamp for the timebase scheduler.
package timebase_pkg;

    localparam int NUM_CH_DEF = 3;
    localparam int DIV_W_DEF  = 16;
    localparam int MIN_DIV    = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        RUN_PEND = 2'd2
    } ch_state_t;

    // A period shorter than two cycles cannot produce a distinct strobe.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : div;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: free-running period counter, active divisor and IDLE/RUN/RUN_PEND control.
module tick_channel
    import timebase_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = 50
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             cfg_hit,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] shadow_div,
    output logic             tick,
    output logic             pending
);

    ch_state_t        state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic             terminal;

    assign terminal = (cnt == div_act - DIV_W'(1));
    assign pending  = (state == RUN_PEND);

    // NOTE: reset is sampled on the clock edge, and every register here uses <= so
    // all channels see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            div_act <= DIV_W'(DEF_DIV);
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (!en) begin
                // Dropping the enable lands any queued divisor right away.
                state <= IDLE;
                cnt   <= '0;
                if (cfg_hit) begin
                    div_act <= cfg_div;
                end else if (state == RUN_PEND) begin
                    div_act <= shadow_div;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state <= RUN;
                        cnt   <= '0;
                        if (cfg_hit) begin
                            div_act <= cfg_div;
                        end
                    end
                    RUN, RUN_PEND: begin
                        if (cfg_hit) begin
                            state <= RUN_PEND;
                        end
                        if (sync) begin
                            cnt <= '0;
                        end else if (terminal) begin
                            tick <= 1'b1;
                            cnt  <= '0;
                            if (state == RUN_PEND) begin
                                div_act <= shadow_div;
                                state   <= RUN;
                            end
                        end else begin
                            cnt <= cnt + DIV_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/timebase_scheduler.sv
// Clock-enable scheduler: NUM_CH programmable tick strobes with a shared one-deep config shadow.
module timebase_scheduler
    import timebase_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = 50
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] tick,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] pending
);

    logic [DIV_W-1:0]  shadow_div;
    logic [DIV_W-1:0]  div_clamped;
    logic [NUM_CH-1:0] hit;
    logic              accept;
    logic              ch_bad;

    // Only one shadow exists, so a queued divisor blocks every channel's config.
    assign cfg_ready   = ~|pending;
    assign accept      = cfg_valid & cfg_ready;
    assign ch_bad      = ({1'b0, cfg_ch} >= 3'(NUM_CH));
    assign div_clamped = DIV_W'(clamp_div(32'(cfg_div)));

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            shadow_div <= DIV_W'(DEF_DIV);
            cfg_err    <= 1'b0;
        end else if (accept) begin
            if (ch_bad) begin
                cfg_err <= 1'b1;
            end else begin
                shadow_div <= div_clamped;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign hit[i] = accept & ~ch_bad & (cfg_ch == 2'(i));

        tick_channel #(
            .DIV_W  (DIV_W),
            .DEF_DIV(DEF_DIV)
        ) u_ch (
            .clk_50MHz (clk_50MHz),
            .reset     (reset),
            .en        (ch_en[i]),
            .sync      (sync),
            .cfg_hit   (hit[i]),
            .cfg_div   (div_clamped),
            .shadow_div(shadow_div),
            .tick      (tick[i]),
            .pending   (pending[i])
        );
    end

endmodule

// File: tb/tb_timebase_scheduler.sv
// Bench for timebase_scheduler: directed scenarios then random traffic against a tick-time model.
module tb_timebase_scheduler;

    localparam int NUM_CH  = 3;
    localparam int DIV_W   = 16;
    localparam int DEF_DIV = 50;

    logic              clk_50MHz = 1'b0;
    logic              reset;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic [NUM_CH-1:0] tick;
    logic              cfg_err;
    logic [NUM_CH-1:0] pending;

    always #10 clk_50MHz = ~clk_50MHz;

    timebase_scheduler #(
        .NUM_CH (NUM_CH),
        .DIV_W  (DIV_W),
        .DEF_DIV(DEF_DIV)
    ) dut (
        .clk_50MHz(clk_50MHz),
        .reset    (reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .ch_en    (ch_en),
        .sync     (sync),
        .tick     (tick),
        .cfg_err  (cfg_err),
        .pending  (pending)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Stimulus held by the driver: pending request plus level inputs.
    bit              req_v  = 1'b0;
    int              req_ch = 0;
    int              req_div = 0;
    bit              rst_r  = 1'b1;
    bit              sync_r = 1'b0;
    bit [NUM_CH-1:0] en_r   = '0;
    bit              primed = 1'b0;

    // Model: each running channel is described by the absolute edge of its next tick.
    bit m_run    [NUM_CH];
    bit m_pend   [NUM_CH];
    int m_div    [NUM_CH];
    int m_next   [NUM_CH];
    int m_shadow [NUM_CH];
    bit m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        bit              ready;
        bit              acc;
        bit              hit;
        int              cd;
        int              t;
        bit [NUM_CH-1:0] exp_tick;
        bit [NUM_CH-1:0] exp_pend;

        @(negedge clk_50MHz);
        cfg_valid = req_v;
        cfg_ch    = 2'(req_ch);
        cfg_div   = DIV_W'(req_div);
        ch_en     = en_r;
        sync      = sync_r;
        reset     = rst_r;

        ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) if (m_pend[i]) ready = 1'b0;
        #1;
        if (primed) check("cfg_ready", 32'(cfg_ready), 32'(ready));

        t        = cyc;
        acc      = req_v && ready && !rst_r;
        cd       = (req_div < 2) ? 2 : req_div;
        exp_tick = '0;

        if (rst_r) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_run[i]  = 1'b0;
                m_pend[i] = 1'b0;
                m_div[i]  = DEF_DIV;
            end
            m_err = 1'b0;
        end else begin
            if (acc && req_ch >= NUM_CH) m_err = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                hit = acc && (req_ch == i);
                if (!en_r[i]) begin
                    if (hit) m_div[i] = cd;
                    else if (m_pend[i]) m_div[i] = m_shadow[i];
                    m_pend[i] = 1'b0;
                    m_run[i]  = 1'b0;
                end else if (!m_run[i]) begin
                    m_run[i] = 1'b1;
                    if (hit) m_div[i] = cd;
                    m_next[i] = t + m_div[i];
                end else begin
                    if (sync_r) begin
                        m_next[i] = t + m_div[i];
                    end else if (t == m_next[i]) begin
                        exp_tick[i] = 1'b1;
                        if (m_pend[i]) begin
                            m_div[i]  = m_shadow[i];
                            m_pend[i] = 1'b0;
                        end
                        m_next[i] = t + m_div[i];
                    end
                    if (hit) begin
                        m_pend[i]   = 1'b1;
                        m_shadow[i] = cd;
                    end
                end
            end
        end

        for (int i = 0; i < NUM_CH; i++) exp_pend[i] = m_pend[i];

        @(posedge clk_50MHz);
        #1;
        cyc++;
        if (rst_r) primed = 1'b1;
        check("tick", 32'(tick), 32'(exp_tick));
        check("pending", 32'(pending), 32'(exp_pend));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
        if (acc) req_v = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic send(input int ch, input int dv);
        req_v   = 1'b1;
        req_ch  = ch;
        req_div = dv;
        for (int k = 0; k < 400 && req_v; k++) step();
        if (req_v) begin
            check("cfg_accept_timeout", 32'(req_v), 32'd0);
            req_v = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            m_run[i] = 1'b0; m_pend[i] = 1'b0; m_div[i] = DEF_DIV;
            m_next[i] = 0; m_shadow[i] = DEF_DIV;
        end
        m_err = 1'b0;

        // Reset, then channel 0 at the default 1 MHz rate.
        rst_r = 1'b1;
        run(2);
        rst_r = 1'b0;
        run(1);
        en_r = 3'b001;
        step();
        run(49);
        check("no_early_tick", 32'(tick), 32'd0);
        step();
        check("first_tick", 32'(tick), 32'b001);

        // Retune at count 20: old period completes, then 100.
        run(20);
        send(0, 100);
        check("pend_after_cfg", 32'(pending), 32'b001);
        check("ready_low", 32'(cfg_ready), 32'd0);
        run(300);

        // Clamped divisors 0 and 1 both give a period of 2.
        send(0, 0);
        run(250);
        send(0, 1);
        run(20);
        check("no_err_on_clamp", 32'(cfg_err), 32'd0);
        send(0, 50);
        run(10);

        // Out-of-range channel index.
        send(3, 7);
        check("cfg_err_set", 32'(cfg_err), 32'd1);
        run(5);
        check("cfg_err_held", 32'(cfg_err), 32'd1);

        // Channel 1 at 75 with an offset phase, then sync.
        send(1, 75);
        run(30);
        en_r = 3'b011;
        run(40);
        sync_r = 1'b1;
        step();
        sync_r = 1'b0;
        run(150);
        check("sync_coincide", 32'(tick[1:0]), 32'b11);

        // Drop channel 1 while its divisor is queued, then re-enable.
        send(1, 20);
        check("pend1", 32'(pending), 32'b010);
        run(3);
        en_r = 3'b001;
        step();
        check("drop_tick1", 32'(tick[1]), 32'd0);
        check("drop_pend", 32'(pending), 32'd0);
        check("drop_ready", 32'(cfg_ready), 32'd1);
        en_r = 3'b011;
        step();
        run(19);
        check("reen_no_tick", 32'(tick[1]), 32'd0);
        step();
        check("reen_tick", 32'(tick[1]), 32'd1);

        // Reset mid-period.
        run(7);
        rst_r = 1'b1;
        step();
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_pend", 32'(pending), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        rst_r = 1'b0;

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(0, 39) == 0) en_r[i] = ~en_r[i];
            sync_r = ($urandom_range(0, 59) == 0);
            rst_r  = ($urandom_range(0, 499) == 0);
            if (!req_v && $urandom_range(0, 7) == 0) begin
                req_v   = 1'b1;
                req_ch  = int'($urandom_range(0, 3));
                req_div = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 120))
                                                      : int'($urandom_range(0, 12));
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
